// File: rtl/pll_pkg.sv
// Shared DPLL definitions: loop filter FSM states, default tuning-word width
// and a saturating signed adder reused by the DCO modulation path.
package pll_pkg;

  localparam int unsigned BIT_COUNT_DEF = 24;

  // Working width of sat_add. The extra internal bit keeps the sum from wrapping.
  localparam int unsigned SAT_W  = 32;
  localparam int unsigned SAT_WW = SAT_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRACK    = 2'd1,
    ST_HOLDOVER = 2'd2
  } pll_state_e;

  // a + b clamped to [-lim, +lim]; lim must be non-negative.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input logic signed [SAT_W-1:0] lim
  );
    logic signed [SAT_WW-1:0] s;
    logic signed [SAT_WW-1:0] l;
    s = SAT_WW'(a) + SAT_WW'(b);
    l = SAT_WW'(lim);
    if (s > l)  return lim;
    if (s < -l) return -lim;
    return SAT_W'(s);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizers for the asynchronous reference and DCO feedback inputs.
// Ports:
//   sys_clk, ext_rst_n : clock, async active-low reset
//   ref_in, fb_in      : asynchronous inputs
//   ref_rise_c         : one-cycle pulse on a synchronized ref_in rise (combinational)
//   fb_s               : feedback bit sampled two flops deep (registered)
module sync_edge_det (
  input  logic sys_clk,
  input  logic ext_rst_n,
  input  logic ref_in,
  input  logic fb_in,
  output logic ref_rise_c,
  output logic fb_s
);

  logic r1, r2, r3;
  logic f1, f2;

  // Two-flop synchronizers; r3 is the delayed copy for edge detection.
  always_ff @(posedge sys_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      r1 <= 1'b0;
      r2 <= 1'b0;
      r3 <= 1'b0;
      f1 <= 1'b0;
      f2 <= 1'b0;
    end else begin
      r1 <= ref_in;
      r2 <= r1;
      r3 <= r2;
      f1 <= fb_in;
      f2 <= f1;
    end
  end

  assign ref_rise_c = r2 & ~r3;
  assign fb_s       = f2;

endmodule

// File: rtl/bbpd_loop_filter.sv
// Bang-bang phase detector plus proportional-integral loop filter producing the
// DCO tuning word, with lock and holdover status.
// Ports:
//   sys_clk, ext_rst_n : clock, async active-low reset
//   enable             : loop enable; low returns to IDLE and freezes integ
//   ref_in             : reference edge input (asynchronous)
//   fb_in              : DCO output fed back (asynchronous)
//   base_word          : nominal free-running tuning word (unsigned)
//   kp, ki             : proportional / integral gains (unsigned)
//   tune_word          : registered, saturated tuning word to the DCO
//   pd_dir             : last phase decision, 1 = speed up
//   locked             : alternating-decision lock indicator
//   holdover           : high while the reference has timed out
module bbpd_loop_filter
  import pll_pkg::*;
#(
  parameter int unsigned bit_count  = BIT_COUNT_DEF,
  parameter int unsigned GAIN_W     = 16,
  parameter int unsigned INTEG_LIM  = 2**20,
  parameter int unsigned LOCK_EDGES = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                 sys_clk,
  input  logic                 ext_rst_n,
  input  logic                 enable,
  input  logic                 ref_in,
  input  logic                 fb_in,
  input  logic [bit_count-1:0] base_word,
  input  logic [GAIN_W-1:0]    kp,
  input  logic [GAIN_W-1:0]    ki,
  output logic [bit_count-1:0] tune_word,
  output logic                 pd_dir,
  output logic                 locked,
  output logic                 holdover
);

  localparam int unsigned INTEG_W = $clog2(INTEG_LIM + 1) + 1;
  localparam int unsigned PROP_W  = GAIN_W + 1;
  localparam int unsigned SUM_W   = bit_count + 2;
  localparam int unsigned LCNT_W  = $clog2(LOCK_EDGES + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT);

  logic ref_rise;
  logic fb_s;
  logic dir_late;

  pll_state_e                 state, state_nxt;
  logic signed [INTEG_W-1:0]  integ, integ_nxt;
  logic signed [PROP_W-1:0]   prop, prop_nxt;
  logic [LCNT_W-1:0]          lock_cnt, lock_cnt_nxt;
  logic [TMO_W-1:0]           tmo_cnt, tmo_cnt_nxt;
  logic                       locked_nxt, pd_dir_nxt, holdover_nxt;
  logic [bit_count-1:0]       tune_nxt;
  logic                       filt;

  logic signed [PROP_W-1:0]   kp_s;
  logic signed [SAT_W-1:0]    ki_step;
  logic signed [SAT_W-1:0]    integ_sum;
  logic                       integ_sum_unused;
  logic signed [SUM_W-1:0]    tune_sum;

  sync_edge_det u_sync (
    .sys_clk    (sys_clk),
    .ext_rst_n  (ext_rst_n),
    .ref_in     (ref_in),
    .fb_in      (fb_in),
    .ref_rise_c (ref_rise),
    .fb_s       (fb_s)
  );

  // Feedback still low at the reference edge means the DCO is late.
  assign dir_late = ~fb_s;

  assign kp_s    = $signed({1'b0, kp});
  assign ki_step = dir_late ? SAT_W'($signed({1'b0, ki})) : -SAT_W'($signed({1'b0, ki}));

  // Saturation keeps the result within INTEG_W; the upper bits only repeat the sign.
  assign integ_sum        = sat_add(SAT_W'(integ), ki_step, SAT_W'(INTEG_LIM));
  assign integ_sum_unused = ^integ_sum[SAT_W-1:INTEG_W];

  // Two guard bits: one for the sign, one so overflow past the top is visible.
  assign tune_sum = $signed({2'b00, base_word}) + SUM_W'(integ) + SUM_W'(prop);

  // State and datapath registers.
  always_ff @(posedge sys_clk or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      state     <= ST_IDLE;
      integ     <= '0;
      prop      <= '0;
      lock_cnt  <= '0;
      tmo_cnt   <= '0;
      locked    <= 1'b0;
      pd_dir    <= 1'b0;
      holdover  <= 1'b0;
      tune_word <= '0;
    end else begin
      state     <= state_nxt;
      integ     <= integ_nxt;
      prop      <= prop_nxt;
      lock_cnt  <= lock_cnt_nxt;
      tmo_cnt   <= tmo_cnt_nxt;
      locked    <= locked_nxt;
      pd_dir    <= pd_dir_nxt;
      holdover  <= holdover_nxt;
      tune_word <= tune_nxt;
    end
  end

  // Next-state, filter and lock logic.
  always_comb begin
    state_nxt    = state;
    integ_nxt    = integ;
    prop_nxt     = prop;
    lock_cnt_nxt = lock_cnt;
    tmo_cnt_nxt  = tmo_cnt;
    locked_nxt   = locked;
    pd_dir_nxt   = pd_dir;
    filt         = 1'b0;

    if (ref_rise) begin
      pd_dir_nxt = dir_late;
    end

    if (!enable) begin
      state_nxt    = ST_IDLE;
      prop_nxt     = '0;
      locked_nxt   = 1'b0;
      lock_cnt_nxt = '0;
      tmo_cnt_nxt  = '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          prop_nxt    = '0;
          tmo_cnt_nxt = '0;
          if (ref_rise) begin
            state_nxt    = ST_TRACK;
            filt         = 1'b1;
            lock_cnt_nxt = '0;
          end
        end
        ST_TRACK: begin
          if (ref_rise) begin
            // A ref edge on the timeout cycle keeps us tracking.
            filt        = 1'b1;
            tmo_cnt_nxt = '0;
            if (dir_late != pd_dir) begin
              if (lock_cnt >= LCNT_W'(LOCK_EDGES - 1)) begin
                lock_cnt_nxt = LCNT_W'(LOCK_EDGES);
                locked_nxt   = 1'b1;
              end else begin
                lock_cnt_nxt = lock_cnt + LCNT_W'(1);
              end
            end else begin
              lock_cnt_nxt = '0;
              locked_nxt   = 1'b0;
            end
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            state_nxt    = ST_HOLDOVER;
            tmo_cnt_nxt  = '0;
            prop_nxt     = '0;
            locked_nxt   = 1'b0;
            lock_cnt_nxt = '0;
          end else begin
            tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
          end
        end
        ST_HOLDOVER: begin
          prop_nxt    = '0;
          locked_nxt  = 1'b0;
          tmo_cnt_nxt = '0;
          if (ref_rise) begin
            state_nxt    = ST_TRACK;
            filt         = 1'b1;
            lock_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase

      if (filt) begin
        prop_nxt  = dir_late ? kp_s : -kp_s;
        integ_nxt = INTEG_W'(integ_sum);
      end
    end
  end

  // Output-side next values: holdover tracks the next state; tune_word saturates.
  always_comb begin
    holdover_nxt = (state_nxt == ST_HOLDOVER);
    if (tune_sum[SUM_W-1]) begin
      tune_nxt = '0;
    end else if (tune_sum[SUM_W-2]) begin
      tune_nxt = '1;
    end else begin
      tune_nxt = tune_sum[bit_count-1:0];
    end
  end

endmodule

// File: tb/tb_bbpd_loop_filter.sv
// Self-checking bench for bbpd_loop_filter: scenario tasks compared against a
// decision-level reference model of the PI filter, lock and holdover rules.
module tb_bbpd_loop_filter;

  localparam int unsigned BC  = 24;
  localparam longint      LIM = longint'(1) << 20;
  localparam int          TMO = 4096;

  logic          sys_clk;
  logic          ext_rst_n;
  logic          enable;
  logic          ref_in;
  logic          fb_in;
  logic [BC-1:0] base_word;
  logic [15:0]   kp;
  logic [15:0]   ki;
  logic [BC-1:0] tune_word;
  logic          pd_dir;
  logic          locked;
  logic          holdover;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_e = 0;

  // Reference model state: mode 0 idle, 1 track, 2 holdover.
  int     m_mode;
  longint m_integ;
  longint m_prop;
  int     m_lcnt;
  bit     m_locked;
  bit     m_last;

  bbpd_loop_filter dut (
    .sys_clk   (sys_clk),
    .ext_rst_n (ext_rst_n),
    .enable    (enable),
    .ref_in    (ref_in),
    .fb_in     (fb_in),
    .base_word (base_word),
    .kp        (kp),
    .ki        (ki),
    .tune_word (tune_word),
    .pd_dir    (pd_dir),
    .locked    (locked),
    .holdover  (holdover)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: time %0t exceeded bound, total=%0d bad=%0d", $time, total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic model_reset();
    m_mode = 0; m_integ = 0; m_prop = 0; m_lcnt = 0; m_locked = 1'b0; m_last = 1'b0;
  endtask

  // One phase decision as seen by the loop filter.
  task automatic model_rise(input bit dir);
    bit     prev;
    longint s;
    prev   = m_last;
    s      = dir ? 1 : -1;
    m_last = dir;
    if (!enable) begin
      m_mode = 0; m_prop = 0; m_locked = 1'b0; m_lcnt = 0;
      return;
    end
    if (m_mode != 1) begin
      m_mode = 1;
      m_lcnt = 0;
    end else if (dir != prev) begin
      m_lcnt = (m_lcnt < 16) ? m_lcnt + 1 : 16;
      if (m_lcnt == 16) m_locked = 1'b1;
    end else begin
      m_lcnt = 0;
      m_locked = 1'b0;
    end
    m_prop  = s * longint'(kp);
    m_integ = m_integ + s * longint'(ki);
    if (m_integ > LIM)  m_integ = LIM;
    if (m_integ < -LIM) m_integ = -LIM;
  endtask

  task automatic model_timeout();
    m_mode = 2; m_prop = 0; m_locked = 1'b0; m_lcnt = 0;
  endtask

  function automatic logic [BC-1:0] exp_tune();
    longint s;
    s = longint'(base_word) + m_integ + m_prop;
    if (s < 0) return '0;
    if (s > longint'(24'hFFFFFF)) return '1;
    return BC'(s);
  endfunction

  // Drive one ref pulse starting no earlier than cycle 'drive'; its rise is
  // evaluated at edge last_e; returns one edge after tune_word has settled.
  task automatic ref_edge_at(input bit dir, input int drive);
    fb_in = !dir;
    tick; tick;
    while (cyc < drive) tick;
    ref_in = 1'b1;
    last_e = cyc + 3;
    tick; tick;
    ref_in = 1'b0;
    tick; tick;
  endtask

  task automatic ref_edge(input bit dir);
    ref_edge_at(dir, 0);
  endtask

  task automatic do_reset();
    ext_rst_n = 1'b0;
    ref_in = 1'b0;
    tick; tick;
    ext_rst_n = 1'b1;
    model_reset();
    tick; tick;
  endtask

  task automatic test_reset();
    ext_rst_n = 1'b0; enable = 1'b1; ref_in = 1'b0; fb_in = 1'b0;
    base_word = 24'h100000; kp = 16'd64; ki = 16'd1;
    model_reset();
    tick; tick;
    total++; if (tune_word !== 24'h0) begin bad++; $display("FAIL rst_tune: got %h want %h", tune_word, 24'h0); end
    total++; if ({pd_dir, locked, holdover} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b want 000", {pd_dir, locked, holdover}); end
    ext_rst_n = 1'b1;
    tick;
    total++; if (tune_word !== 24'h100000) begin bad++; $display("FAIL first_edge_tune: got %h want 100000", tune_word); end
    repeat (5) tick;
    total++; if (tune_word !== 24'h100000) begin bad++; $display("FAIL idle_tune: got %h want 100000", tune_word); end
    total++; if ({pd_dir, locked, holdover} !== 3'b000) begin bad++; $display("FAIL idle_flags: got %b want 000", {pd_dir, locked, holdover}); end
  endtask

  task automatic test_single_late();
    fb_in = 1'b0;
    tick; tick;
    ref_in = 1'b1;
    tick;  // edge k samples ref high
    tick;  // k+1
    ref_in = 1'b0;
    total++; if (pd_dir !== 1'b0) begin bad++; $display("FAIL late_pd_k1: got %b want 0", pd_dir); end
    tick;  // k+2
    total++; if (pd_dir !== 1'b1) begin bad++; $display("FAIL late_pd_k2: got %b want 1", pd_dir); end
    total++; if (tune_word !== 24'h100000) begin bad++; $display("FAIL late_tune_k2: got %h want 100000", tune_word); end
    tick;  // k+3
    total++; if (tune_word !== 24'h100041) begin bad++; $display("FAIL late_tune_k3: got %h want 100041", tune_word); end
    model_rise(1'b1);
    tick; tick;
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      bit dir;
      dir = 1'($urandom_range(0, 1));
      kp  = 16'($urandom_range(0, 65535));
      ki  = 16'($urandom_range(0, 4095));
      if (i % 8 == 0) base_word = 24'($urandom);
      ref_edge(dir);
      model_rise(dir);
      total++; if (tune_word !== exp_tune()) begin bad++; $display("FAIL rand_tune[%0d]: got %h want %h", i, tune_word, exp_tune()); end
      total++; if ({pd_dir, locked, holdover} !== {m_last, m_locked, 1'b0}) begin
        bad++; $display("FAIL rand_flags[%0d]: got %b want %b", i, {pd_dir, locked, holdover}, {m_last, m_locked, 1'b0});
      end
    end
  endtask

  task automatic test_lock();
    base_word = 24'h100000; kp = 16'd64; ki = 16'd1;
    ref_edge(1'b1); model_rise(1'b1);
    ref_edge(1'b1); model_rise(1'b1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_pre: got %b want 0", locked); end
    for (int i = 1; i <= 16; i++) begin
      bit dir;
      dir = (i % 2 == 0);
      ref_edge(dir);
      model_rise(dir);
      total++; if (locked !== m_locked) begin bad++; $display("FAIL lock_edge[%0d]: got %b want %b", i, locked, m_locked); end
      if (i == 15) begin
        total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_15: got %b want 0", locked); end
      end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_16: got %b want 1", locked); end
    ref_edge(1'b1); model_rise(1'b1);
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_repeat: got %b want 0", locked); end
    total++; if (tune_word !== exp_tune()) begin bad++; $display("FAIL lock_tune: got %h want %h", tune_word, exp_tune()); end
  endtask

  task automatic test_enable_race();
    fb_in = 1'b0;
    tick; tick;
    ref_in = 1'b1;
    tick; tick;
    enable = 1'b0;
    ref_in = 1'b0;
    tick; tick;
    model_rise(1'b1);
    total++; if (tune_word !== exp_tune()) begin bad++; $display("FAIL en_race_tune: got %h want %h", tune_word, exp_tune()); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL en_race_locked: got %b want 0", locked); end
    enable = 1'b1;
    tick; tick;
    ref_edge(1'b0); model_rise(1'b0);
    total++; if (tune_word !== exp_tune()) begin bad++; $display("FAIL en_resume_tune: got %h want %h", tune_word, exp_tune()); end
  endtask

  task automatic test_holdover();
    int e2;
    ref_edge(1'b1); model_rise(1'b1);
    while (cyc < last_e + TMO - 1) tick;
    total++; if (holdover !== 1'b0) begin bad++; $display("FAIL hold_early: got %b want 0", holdover); end
    tick;
    model_timeout();
    total++; if (holdover !== 1'b1) begin bad++; $display("FAIL hold_entry: got %b want 1", holdover); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL hold_locked: got %b want 0", locked); end
    tick;
    total++; if (tune_word !== exp_tune()) begin bad++; $display("FAIL hold_tune: got %h want %h", tune_word, exp_tune()); end
    ref_edge(1'b0); model_rise(1'b0);
    total++; if (holdover !== 1'b0) begin bad++; $display("FAIL hold_exit: got %b want 0", holdover); end
    total++; if (tune_word !== exp_tune()) begin bad++; $display("FAIL hold_exit_tune: got %h want %h", tune_word, exp_tune()); end
    e2 = last_e;
    // Rise lands on the very cycle the timeout count completes.
    ref_edge_at(1'b1, e2 + TMO - 3);
    model_rise(1'b1);
    total++; if (last_e !== e2 + TMO) begin bad++; $display("FAIL race_align: got %0d want %0d", last_e, e2 + TMO); end
    total++; if (holdover !== 1'b0) begin bad++; $display("FAIL race_hold: got %b want 0", holdover); end
    total++; if (tune_word !== exp_tune()) begin bad++; $display("FAIL race_tune: got %h want %h", tune_word, exp_tune()); end
    total++; if (pd_dir !== 1'b1) begin bad++; $display("FAIL race_pd: got %b want 1", pd_dir); end
  endtask

  task automatic test_integ_sat();
    ext_rst_n = 1'b0;
    #1;
    total++; if ({tune_word, pd_dir, locked, holdover} !== 27'h0) begin
      bad++; $display("FAIL mid_reset: got %h want 0", {tune_word, pd_dir, locked, holdover});
    end
    tick;
    ext_rst_n = 1'b1;
    model_reset();
    base_word = 24'h100000; kp = 16'd64; ki = 16'h4000;
    tick; tick;
    for (int i = 0; i < 100; i++) begin
      ref_edge(1'b1);
      model_rise(1'b1);
      total++; if (tune_word !== exp_tune()) begin bad++; $display("FAIL sat_tune[%0d]: got %h want %h", i, tune_word, exp_tune()); end
    end
    total++; if (tune_word !== 24'h200040) begin bad++; $display("FAIL sat_final: got %h want 200040", tune_word); end
  endtask

  task automatic test_clamp();
    do_reset();
    base_word = 24'hFFFFF0; kp = 16'd64; ki = 16'd1;
    for (int i = 0; i < 3; i++) begin
      ref_edge(1'b1); model_rise(1'b1);
      total++; if (tune_word !== 24'hFFFFFF) begin bad++; $display("FAIL clamp_hi[%0d]: got %h want ffffff", i, tune_word); end
    end
    do_reset();
    base_word = 24'h000010;
    for (int i = 0; i < 3; i++) begin
      ref_edge(1'b0); model_rise(1'b0);
      total++; if (tune_word !== 24'h000000) begin bad++; $display("FAIL clamp_lo[%0d]: got %h want 000000", i, tune_word); end
    end
  endtask

  initial begin
    test_reset();
    test_single_late();
    test_random();
    test_lock();
    test_enable_race();
    test_holdover();
    test_integ_sat();
    test_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
